blimp_mem_arbiter: RTL and testbench
====================================

Name: blimp_mem_arbiter

Overview:
- Shares one downstream memory port between the instruction-fetch requester (imem) and the load/store requester (dmem) of the BlimpV6 core.
- Arbitrates requests round-robin.
- Records the source of every issued request in an in-order tracking FIFO, and uses it to steer each in-order memory response back to the right requester.
- Sits between the core's two memory interfaces and the test-harness/fabric memory. Opaque fields pass through unmodified.

Parameters:
p_req_bits, 100, width of a memory request message (op, opaque, addr, len, data); passed through opaquely
p_resp_bits, 68, width of a memory response message; passed through opaquely
p_max_inflight, 4, depth of the source-tracking FIFO (≥1); maximum number of outstanding requests

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
imem_req_val  input  1  imem request valid
imem_req_rdy  output  1  imem request ready
imem_req_msg  input  p_req_bits  imem request
dmem_req_val  input  1  dmem request valid
dmem_req_rdy  output  1  dmem request ready
dmem_req_msg  input  p_req_bits  dmem request
mem_req_val  output  1  downstream request valid
mem_req_rdy  input  1  downstream request ready
mem_req_msg  output  p_req_bits  downstream request
mem_resp_val  input  1  downstream response valid
mem_resp_rdy  output  1  downstream response ready
mem_resp_msg  input  p_resp_bits  downstream response
imem_resp_val  output  1  imem response valid
imem_resp_rdy  input  1  imem response ready
imem_resp_msg  output  p_resp_bits  imem response
dmem_resp_val  output  1  dmem response valid
dmem_resp_rdy  input  1  dmem response ready
dmem_resp_msg  output  p_resp_bits  dmem response

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Handshake: val/rdy on every interface. A transfer fires when val && rdy at a clk rising edge.
- State:
  - last_grant (1 bit: 0=imem, 1=dmem), reset 1, so imem wins the first conflict.
  - Tracking FIFO of 1-bit source IDs: head/tail pointers wrap modulo p_max_inflight; count width $clog2(p_max_inflight+1). Reset: empty, count=0.
- Grant selection (combinational, from valids and last_grant only):
  - Only one valid: that requester is selected.
  - Both valid: the requester that is not last_grant is selected.
- Request path (zero latency, combinational):
  - mem_req_val = (imem_req_val | dmem_req_val) & !full.
  - mem_req_msg = message of the selected requester, or 0 when none is valid.
  - Selected requester's req_rdy = mem_req_rdy & !full. The other requester's req_rdy = 0.
  - On a mem_req fire: push the source ID; last_grant <= selected source.
  - mem_req_val never depends on mem_req_rdy.
- Full:
  - full = (count == p_max_inflight), from registered count.
  - A pop in the same cycle does not unblock a push; the push waits one cycle.
- Response path (zero latency):
  - Empty FIFO: mem_resp_rdy = 0, and imem/dmem_resp_val = 0.
  - Otherwise, head source H receives resp_val = mem_resp_val and resp_msg = mem_resp_msg. The other requester's resp_val = 0.
  - mem_resp_rdy = H's resp_rdy. On a fire, pop.
  - Resp_msg outputs are 0 when not routed.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Responses must return in request order. This is a system contract, not checked.
- Reset mid-operation:
  - All state clears immediately and outstanding entries are discarded.
  - The downstream memory is reset by the same rst_n.
- Outputs during reset: all val/rdy outputs 0, all msg outputs 0.

Optional Feature:
Macro BLIMP_MEM_ARBITER_PERF_EN.
- When defined, adds three 32-bit output ports, all reset to 0 and wrapping on overflow:
  - perf_imem_grants: increments per imem request fire.
  - perf_dmem_grants: increments per dmem request fire.
  - perf_conflict_cycles: increments every cycle both req_val are high.
- When undefined, these ports and their registers do not exist. Behaviour is otherwise identical.

Test Plan:
- Single imem request, addr field 0x100, with mem_req_rdy=1 → mem_req_msg equals imem_req_msg in the same cycle. Memory response 0xCAFE returns on imem_resp_msg only; dmem_resp_val stays 0.
- Both requesters valid for 4 consecutive cycles with memory always ready → grants in order imem, dmem, imem, dmem. Responses are routed in the same order.
- p_max_inflight=4, responses withheld → after 4 fires, mem_req_val=0 and both req_rdy=0. One response fires with a new request pending → the new request issues on the next cycle, not the same cycle.
- Head source is dmem, dmem_resp_rdy=0, mem_resp_val=1 → mem_resp_rdy=0 and the response is held. Raise dmem_resp_rdy → the response fires and count decrements by 1.
- Drive rst_n low asynchronously (mid-cycle) with 2 requests outstanding → count=0 and all outputs 0 immediately, before the next clk edge. After release, the first conflict grants imem.
- With BLIMP_MEM_ARBITER_PERF_EN defined, run the scenario-2 stimulus → perf_imem_grants=2, perf_dmem_grants=2, perf_conflict_cycles=4.

Source files
------------

// File: rtl/blimp_mem_arbiter.sv
// blimp_mem_arbiter
// Shares one downstream memory port between the BlimpV6 instruction-fetch
// requester (imem) and load/store requester (dmem). Requests are granted
// round-robin. The source of each issued request is recorded in an in-order
// tracking FIFO, and the FIFO head steers each in-order response back to the
// requester that issued it. Message payloads pass through untouched.
//
// Handshake: every interface is val/rdy. A transfer happens on a rising clk
// edge where val && rdy. mem_req_val never depends on mem_req_rdy.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   imem_req_* / dmem_req_*        upstream requests (val in, rdy out, msg in)
//   mem_req_*                      downstream request (val out, rdy in, msg out)
//   mem_resp_*                     downstream response (val in, rdy out, msg in)
//   imem_resp_* / dmem_resp_*      upstream responses (val out, rdy in, msg out)
//   perf_*  (BLIMP_MEM_ARBITER_PERF_EN only) 32-bit wrapping event counters
//
// Optional feature macro: BLIMP_MEM_ARBITER_PERF_EN adds perf_imem_grants,
// perf_dmem_grants and perf_conflict_cycles.
module blimp_mem_arbiter #(
  parameter int p_req_bits     = 100,
  parameter int p_resp_bits    = 68,
  parameter int p_max_inflight = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_req_val,
  output logic                   imem_req_rdy,
  input  logic [p_req_bits-1:0]  imem_req_msg,
  input  logic                   dmem_req_val,
  output logic                   dmem_req_rdy,
  input  logic [p_req_bits-1:0]  dmem_req_msg,
  output logic                   mem_req_val,
  input  logic                   mem_req_rdy,
  output logic [p_req_bits-1:0]  mem_req_msg,
  input  logic                   mem_resp_val,
  output logic                   mem_resp_rdy,
  input  logic [p_resp_bits-1:0] mem_resp_msg,
  output logic                   imem_resp_val,
  input  logic                   imem_resp_rdy,
  output logic [p_resp_bits-1:0] imem_resp_msg,
  output logic                   dmem_resp_val,
  input  logic                   dmem_resp_rdy,
  output logic [p_resp_bits-1:0] dmem_resp_msg
`ifdef BLIMP_MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]            perf_imem_grants,
  output logic [31:0]            perf_dmem_grants,
  output logic [31:0]            perf_conflict_cycles
`endif
);

  localparam int CW = $clog2(p_max_inflight + 1);
  localparam int PW = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1;

  // Source IDs: 0 = imem, 1 = dmem.
  logic                      last_grant_q, last_grant_d;
  logic [p_max_inflight-1:0] src_q, src_d;
  logic [PW-1:0]             head_q, head_d;
  logic [PW-1:0]             tail_q, tail_d;
  logic [CW-1:0]             count_q, count_d;

  logic imem_sel, dmem_sel;
  logic full, empty, head_src;
  logic push, pop;

  assign full     = (count_q == CW'(p_max_inflight));
  assign empty    = (count_q == '0);
  assign head_src = src_q[head_q];

  // Grant: a lone requester wins; on conflict the one not granted last wins.
  assign imem_sel = imem_req_val & (~dmem_req_val | last_grant_q);
  assign dmem_sel = dmem_req_val & (~imem_req_val | ~last_grant_q);

  // All outputs are forced to zero while rst_n is low, even if the upstream
  // requesters keep driving valid.
  always_comb begin
    mem_req_val   = rst_n & (imem_req_val | dmem_req_val) & ~full;
    imem_req_rdy  = rst_n & imem_sel & mem_req_rdy & ~full;
    dmem_req_rdy  = rst_n & dmem_sel & mem_req_rdy & ~full;
    mem_req_msg   = '0;
    if (rst_n && imem_sel)      mem_req_msg = imem_req_msg;
    else if (rst_n && dmem_sel) mem_req_msg = dmem_req_msg;

    imem_resp_val = 1'b0;
    dmem_resp_val = 1'b0;
    imem_resp_msg = '0;
    dmem_resp_msg = '0;
    mem_resp_rdy  = 1'b0;
    if (rst_n && !empty) begin
      if (head_src) begin
        dmem_resp_val = mem_resp_val;
        dmem_resp_msg = mem_resp_msg;
        mem_resp_rdy  = dmem_resp_rdy;
      end else begin
        imem_resp_val = mem_resp_val;
        imem_resp_msg = mem_resp_msg;
        mem_resp_rdy  = imem_resp_rdy;
      end
    end
  end

  assign push = mem_req_val & mem_req_rdy;
  assign pop  = mem_resp_val & mem_resp_rdy;

  always_comb begin
    last_grant_d = last_grant_q;
    src_d        = src_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    if (push) begin
      last_grant_d  = dmem_sel;
      src_d[tail_q] = dmem_sel;
      tail_d        = (tail_q == PW'(p_max_inflight - 1)) ? '0 : tail_q + 1'b1;
    end
    if (pop) begin
      head_d = (head_q == PW'(p_max_inflight - 1)) ? '0 : head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;  // imem wins the first conflict
      src_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

`ifdef BLIMP_MEM_ARBITER_PERF_EN
  logic [31:0] perf_imem_q, perf_imem_d;
  logic [31:0] perf_dmem_q, perf_dmem_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  always_comb begin
    perf_imem_d = perf_imem_q;
    perf_dmem_d = perf_dmem_q;
    perf_conf_d = perf_conf_q;
    if (push && imem_sel)               perf_imem_d = perf_imem_q + 32'd1;
    if (push && dmem_sel)               perf_dmem_d = perf_dmem_q + 32'd1;
    if (imem_req_val && dmem_req_val)   perf_conf_d = perf_conf_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_imem_q <= '0;
      perf_dmem_q <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_imem_q <= perf_imem_d;
      perf_dmem_q <= perf_dmem_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  assign perf_imem_grants     = perf_imem_q;
  assign perf_dmem_grants     = perf_dmem_q;
  assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: tb/tb_blimp_mem_arbiter.sv
// Directed testbench for blimp_mem_arbiter (default parameters, depth 4).
// Inputs change on the falling clk edge; outputs are checked 1 ns later.
module tb_blimp_mem_arbiter;

  localparam int RQ = 100;
  localparam int RS = 68;

  logic          clk;
  logic          rst_n;
  logic          imem_req_val, imem_req_rdy;
  logic [RQ-1:0] imem_req_msg;
  logic          dmem_req_val, dmem_req_rdy;
  logic [RQ-1:0] dmem_req_msg;
  logic          mem_req_val, mem_req_rdy;
  logic [RQ-1:0] mem_req_msg;
  logic          mem_resp_val, mem_resp_rdy;
  logic [RS-1:0] mem_resp_msg;
  logic          imem_resp_val, imem_resp_rdy;
  logic [RS-1:0] imem_resp_msg;
  logic          dmem_resp_val, dmem_resp_rdy;
  logic [RS-1:0] dmem_resp_msg;
`ifdef BLIMP_MEM_ARBITER_PERF_EN
  logic [31:0]   perf_imem_grants, perf_dmem_grants, perf_conflict_cycles;
`endif

  int total = 0;
  int bad   = 0;

  logic [0:0] exp_q[$];

  blimp_mem_arbiter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_val  (imem_req_val),
    .imem_req_rdy  (imem_req_rdy),
    .imem_req_msg  (imem_req_msg),
    .dmem_req_val  (dmem_req_val),
    .dmem_req_rdy  (dmem_req_rdy),
    .dmem_req_msg  (dmem_req_msg),
    .mem_req_val   (mem_req_val),
    .mem_req_rdy   (mem_req_rdy),
    .mem_req_msg   (mem_req_msg),
    .mem_resp_val  (mem_resp_val),
    .mem_resp_rdy  (mem_resp_rdy),
    .mem_resp_msg  (mem_resp_msg),
    .imem_resp_val (imem_resp_val),
    .imem_resp_rdy (imem_resp_rdy),
    .imem_resp_msg (imem_resp_msg),
    .dmem_resp_val (dmem_resp_val),
    .dmem_resp_rdy (dmem_resp_rdy),
    .dmem_resp_msg (dmem_resp_msg)
`ifdef BLIMP_MEM_ARBITER_PERF_EN
    ,
    .perf_imem_grants     (perf_imem_grants),
    .perf_dmem_grants     (perf_dmem_grants),
    .perf_conflict_cycles (perf_conflict_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    imem_req_val  = 1'b0;
    imem_req_msg  = '0;
    dmem_req_val  = 1'b0;
    dmem_req_msg  = '0;
    mem_req_rdy   = 1'b0;
    mem_resp_val  = 1'b0;
    mem_resp_msg  = '0;
    imem_resp_rdy = 1'b0;
    dmem_resp_rdy = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    imem_req_val = 1'b1;
    imem_req_msg = 100'h5;
    mem_req_rdy  = 1'b1;
    #1;
    total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL rst_mem_req_val got=%b want=0", mem_req_val); end
    total++; if (imem_req_rdy !== 1'b0) begin bad++; $display("FAIL rst_imem_req_rdy got=%b want=0", imem_req_rdy); end
    total++; if (mem_req_msg !== '0) begin bad++; $display("FAIL rst_mem_req_msg got=%h want=0", mem_req_msg); end
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", dut.count_q); end
    do_reset();
  endtask

  task automatic test_single();
    logic [RQ-1:0] m;
    m = 100'h00000_00000100_00000000;  // addr field 0x100
    do_reset();
    @(negedge clk);
    imem_req_val = 1'b1;
    imem_req_msg = m;
    mem_req_rdy  = 1'b1;
    #1;
    total++; if (mem_req_val !== 1'b1) begin bad++; $display("FAIL single_req_val got=%b want=1", mem_req_val); end
    total++; if (mem_req_msg !== m) begin bad++; $display("FAIL single_req_msg got=%h want=%h", mem_req_msg, m); end
    total++; if (imem_req_rdy !== 1'b1 || dmem_req_rdy !== 1'b0) begin bad++; $display("FAIL single_rdy got=%b%b want=10", imem_req_rdy, dmem_req_rdy); end
    @(negedge clk);
    imem_req_val  = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_msg  = 68'hCAFE;
    imem_resp_rdy = 1'b1;
    dmem_resp_rdy = 1'b1;
    #1;
    total++; if (dut.count_q !== 3'd1) begin bad++; $display("FAIL single_count got=%0d want=1", dut.count_q); end
    total++; if (imem_resp_val !== 1'b1 || imem_resp_msg !== 68'hCAFE) begin bad++; $display("FAIL single_imem_resp got=%b/%h want=1/cafe", imem_resp_val, imem_resp_msg); end
    total++; if (dmem_resp_val !== 1'b0 || dmem_resp_msg !== '0) begin bad++; $display("FAIL single_dmem_resp got=%b/%h want=0/0", dmem_resp_val, dmem_resp_msg); end
    total++; if (mem_resp_rdy !== 1'b1) begin bad++; $display("FAIL single_resp_rdy got=%b want=1", mem_resp_rdy); end
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL single_count_after got=%0d want=0", dut.count_q); end
    drive_idle();
  endtask

  task automatic test_round_robin();
    logic [RQ-1:0] a, b, want;
    logic [0:0]    src;
    a = 100'hA0A0;
    b = 100'hB0B0;
    do_reset();
    // Conflicts after reset must alternate imem, dmem, imem, dmem.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_req_val = 1'b1; imem_req_msg = a;
      dmem_req_val = 1'b1; dmem_req_msg = b;
      mem_req_rdy  = 1'b1;
      #1;
      want = (i % 2 == 0) ? a : b;
      total++; if (mem_req_msg !== want) begin bad++; $display("FAIL rr_grant%0d got=%h want=%h", i, mem_req_msg, want); end
      total++; if (imem_req_rdy !== (i % 2 == 0)) begin bad++; $display("FAIL rr_imem_rdy%0d got=%b want=%b", i, imem_req_rdy, (i % 2 == 0)); end
      exp_q.push_back((i % 2 == 0) ? 1'b0 : 1'b1);
    end
    @(negedge clk);
    imem_req_val = 1'b0;
    dmem_req_val = 1'b0;
    imem_resp_rdy = 1'b1;
    dmem_resp_rdy = 1'b1;
    #1;
    total++; if (dut.count_q !== 3'd4) begin bad++; $display("FAIL rr_count got=%0d want=4", dut.count_q); end
`ifdef BLIMP_MEM_ARBITER_PERF_EN
    total++; if (perf_imem_grants !== 32'd2) begin bad++; $display("FAIL perf_imem got=%0d want=2", perf_imem_grants); end
    total++; if (perf_dmem_grants !== 32'd2) begin bad++; $display("FAIL perf_dmem got=%0d want=2", perf_dmem_grants); end
    total++; if (perf_conflict_cycles !== 32'd4) begin bad++; $display("FAIL perf_conflict got=%0d want=4", perf_conflict_cycles); end
`endif
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      mem_resp_val = 1'b1;
      mem_resp_msg = 68'h10 + 68'(i);
      #1;
      src = exp_q.pop_front();
      total++; if (imem_resp_val !== ~src[0] || dmem_resp_val !== src[0]) begin bad++; $display("FAIL rr_route%0d got=%b%b want=%b%b", i, imem_resp_val, dmem_resp_val, ~src[0], src[0]); end
    end
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL rr_drained got=%0d want=0", dut.count_q); end
    drive_idle();
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      imem_req_val = 1'b1; imem_req_msg = 100'h1 + 100'(i);
      mem_req_rdy  = 1'b1;
    end
    @(negedge clk);
    dmem_req_val = 1'b1; dmem_req_msg = 100'hD;
    #1;
    total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL full_req_val got=%b want=0", mem_req_val); end
    total++; if (imem_req_rdy !== 1'b0 || dmem_req_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy got=%b%b want=00", imem_req_rdy, dmem_req_rdy); end
    mem_resp_val  = 1'b1;
    mem_resp_msg  = 68'h77;
    imem_resp_rdy = 1'b1;
    #1;
    total++; if (mem_resp_rdy !== 1'b1) begin bad++; $display("FAIL full_resp_rdy got=%b want=1", mem_resp_rdy); end
    total++; if (mem_req_val !== 1'b0) begin bad++; $display("FAIL full_same_cycle got=%b want=0", mem_req_val); end
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd3) begin bad++; $display("FAIL full_count_pop got=%0d want=3", dut.count_q); end
    total++; if (mem_req_val !== 1'b1 || dmem_req_rdy !== 1'b1) begin bad++; $display("FAIL full_next_issue got=%b/%b want=1/1", mem_req_val, dmem_req_rdy); end
    drive_idle();
  endtask

  task automatic test_resp_hold();
    do_reset();
    @(negedge clk);
    dmem_req_val = 1'b1; dmem_req_msg = 100'h42;
    mem_req_rdy  = 1'b1;
    @(negedge clk);
    dmem_req_val  = 1'b0;
    mem_resp_val  = 1'b1;
    mem_resp_msg  = 68'hBEEF;
    imem_resp_rdy = 1'b1;
    dmem_resp_rdy = 1'b0;
    #1;
    total++; if (mem_resp_rdy !== 1'b0) begin bad++; $display("FAIL hold_resp_rdy got=%b want=0", mem_resp_rdy); end
    total++; if (dmem_resp_val !== 1'b1 || imem_resp_val !== 1'b0) begin bad++; $display("FAIL hold_route got=%b%b want=01", imem_resp_val, dmem_resp_val); end
    @(negedge clk);
    total++; if (dut.count_q !== 3'd1) begin bad++; $display("FAIL hold_count got=%0d want=1", dut.count_q); end
    dmem_resp_rdy = 1'b1;
    #1;
    total++; if (mem_resp_rdy !== 1'b1 || dmem_resp_msg !== 68'hBEEF) begin bad++; $display("FAIL hold_release got=%b/%h want=1/beef", mem_resp_rdy, dmem_resp_msg); end
    @(negedge clk);
    mem_resp_val = 1'b0;
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL hold_count_after got=%0d want=0", dut.count_q); end
    drive_idle();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      imem_req_val = 1'b1; imem_req_msg = 100'h9;
      mem_req_rdy  = 1'b1;
    end
    @(negedge clk);
    mem_resp_val  = 1'b1;
    mem_resp_msg  = 68'h55;
    imem_resp_rdy = 1'b1;
    #1;
    total++; if (dut.count_q !== 3'd2) begin bad++; $display("FAIL ar_count_before got=%0d want=2", dut.count_q); end
    #1;
    rst_n = 1'b0;  // mid-cycle, away from any clk edge
    #1;
    total++; if (dut.count_q !== 3'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", dut.count_q); end
    total++; if ({mem_req_val, imem_req_rdy, dmem_req_rdy, mem_resp_rdy, imem_resp_val, dmem_resp_val} !== 6'b0) begin bad++; $display("FAIL ar_vals got=%b want=000000", {mem_req_val, imem_req_rdy, dmem_req_rdy, mem_resp_rdy, imem_resp_val, dmem_resp_val}); end
    total++; if (mem_req_msg !== '0 || imem_resp_msg !== '0 || dmem_resp_msg !== '0) begin bad++; $display("FAIL ar_msgs got=%h/%h/%h want=0", mem_req_msg, imem_resp_msg, dmem_resp_msg); end
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    imem_req_val = 1'b1; dmem_req_val = 1'b1;
    mem_req_rdy  = 1'b1;
    #1;
    total++; if (imem_req_rdy !== 1'b1 || dmem_req_rdy !== 1'b0) begin bad++; $display("FAIL ar_first_conflict got=%b%b want=10", imem_req_rdy, dmem_req_rdy); end
    @(negedge clk);
    drive_idle();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    drive_idle();
    rst_n = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_full();
    test_resp_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
